// File: rtl/sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sseg_scan_ctrl
// Purpose  : Time-multiplexed scan controller for a 4-digit common-anode
//            seven-segment display. By default the display shows the floppy
//            track number as "F", blank, then the track in hex. A requester
//            can override the display with a 4-nibble status code. The code
//            stays on the display for HOLD_FRAMES scan frames.
// Ports    : clk      - system clock
//            rst      - asynchronous reset, active-high
//            track    - floppy track number (0..127)
//            ovr_req  - override request, sampled every cycle
//            ovr_code - override nibbles, [15:12] = digit 3 ... [3:0] = digit 0
//            ovr_ack  - one-cycle pulse: request accepted, code latched
//            busy     - high while the override is on the display
//            seg_n    - segments g..a, active-low, registered
//            dig_n    - digit enables, active-low, bit i = digit i, registered
// Revision : 1.0 - initial release
// ============================================================================
module sseg_scan_ctrl #(
    parameter int SCAN_DIV    = 1024,
    parameter int BLANK_CYC   = 16,
    parameter int HOLD_FRAMES = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  track,
    input  logic        ovr_req,
    input  logic [15:0] ovr_code,
    output logic        ovr_ack,
    output logic        busy,
    output logic [6:0]  seg_n,
    output logic [3:0]  dig_n
);

    localparam int DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int HOLD_W = $clog2(HOLD_FRAMES + 1);

    localparam logic [DIV_W-1:0]  c_div_max = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIV_W-1:0]  c_blank   = DIV_W'(BLANK_CYC);
    localparam logic [HOLD_W-1:0] c_hold    = HOLD_W'(HOLD_FRAMES);
    localparam logic [HOLD_W-1:0] c_hold_1  = HOLD_W'(1);

    typedef enum logic [0:0] {
        SHOW_TRK = 1'b0,
        SHOW_OVR = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [DIV_W-1:0]    r_div;
    logic [1:0]          r_idx;
    logic [6:0]          r_snap;
    logic [15:0]         r_code;
    logic [15:0]         w_code_nxt;
    logic [HOLD_W-1:0]   r_hold;
    logic [HOLD_W-1:0]   w_hold_nxt;
    logic                w_slot_end;
    logic                w_frame_end;
    logic                w_frame_start;
    logic [6:0]          w_seg_lit;

    // Active-low gfedcba hex font.
    function automatic logic [6:0] font(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    assign w_slot_end    = (r_div == c_div_max);
    assign w_frame_end   = w_slot_end && (r_idx == 2'd3);
    assign w_frame_start = (r_div == '0) && (r_idx == 2'd0);
    assign busy          = (r_state == SHOW_OVR);

    // Scan divider, digit index and per-frame track snapshot. Taking the
    // snapshot in the first (always blanked) cycle of the frame means every
    // lit slot in that frame sees the same track value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_div  <= '0;
            r_idx  <= 2'd0;
            r_snap <= 7'd0;
        end else begin
            if (w_slot_end) begin
                r_div <= '0;
                r_idx <= r_idx + 2'd1;
            end else begin
                r_div <= r_div + 1'b1;
            end
            if (w_frame_start) begin
                r_snap <= track;
            end
        end
    end

    // Display-source state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= SHOW_TRK;
            r_code  <= 16'h0000;
            r_hold  <= '0;
            ovr_ack <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_code  <= w_code_nxt;
            r_hold  <= w_hold_nxt;
            ovr_ack <= ovr_req;
        end
    end

    // A request always wins, including over the expiry of the current hold,
    // so a back-to-back override shows no gap on the display.
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        w_hold_nxt  = r_hold;
        if (ovr_req) begin
            w_state_nxt = SHOW_OVR;
            w_code_nxt  = ovr_code;
            w_hold_nxt  = c_hold;
        end else if ((r_state == SHOW_OVR) && w_frame_end) begin
            if (r_hold == c_hold_1) begin
                w_state_nxt = SHOW_TRK;
                w_hold_nxt  = '0;
            end else begin
                w_hold_nxt  = r_hold - c_hold_1;
            end
        end
    end

    // Segment pattern for the digit currently being scanned.
    always_comb begin
        w_seg_lit = 7'h7F;
        if (r_state == SHOW_OVR) begin
            case (r_idx)
                2'd3:    w_seg_lit = font(r_code[15:12]);
                2'd2:    w_seg_lit = font(r_code[11:8]);
                2'd1:    w_seg_lit = font(r_code[7:4]);
                default: w_seg_lit = font(r_code[3:0]);
            endcase
        end else begin
            case (r_idx)
                2'd3:    w_seg_lit = 7'h0E;
                2'd2:    w_seg_lit = 7'h7F;
                2'd1:    w_seg_lit = font({1'b0, r_snap[6:4]});
                default: w_seg_lit = font(r_snap[3:0]);
            endcase
        end
    end

    // Registered pin drive with a blanking guard at the start of every slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_n <= 7'h7F;
            dig_n <= 4'hF;
        end else if (r_div < c_blank) begin
            seg_n <= 7'h7F;
            dig_n <= 4'hF;
        end else begin
            seg_n <= w_seg_lit;
            dig_n <= ~(4'b0001 << r_idx);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sseg_scan_ctrl
// Purpose  : Randomized self-checking bench for sseg_scan_ctrl. Two instances
//            share the stimulus: one with (8,2,3) and one with (3,1,1) for
//            SCAN_DIV, BLANK_CYC and HOLD_FRAMES. A cycle-count reference
//            model predicts the pins of each instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  track;
    logic        ovr_req;
    logic [15:0] ovr_code;

    logic        ack0, busy0, ack1, busy1;
    logic [6:0]  seg0, seg1;
    logic [3:0]  dig0, dig1;

    always #5 clk = ~clk;

    sseg_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2), .HOLD_FRAMES(3)) u_dut0 (
        .clk(clk), .rst(rst), .track(track), .ovr_req(ovr_req),
        .ovr_code(ovr_code), .ovr_ack(ack0), .busy(busy0),
        .seg_n(seg0), .dig_n(dig0)
    );

    sseg_scan_ctrl #(.SCAN_DIV(3), .BLANK_CYC(1), .HOLD_FRAMES(1)) u_dut1 (
        .clk(clk), .rst(rst), .track(track), .ovr_req(ovr_req),
        .ovr_code(ovr_code), .ovr_ack(ack1), .busy(busy1),
        .seg_n(seg1), .dig_n(dig1)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got=%h expected=%h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int         p_div  [2] = '{8, 3};
    int         p_blank[2] = '{2, 1};
    int         p_hold [2] = '{3, 1};
    logic [6:0] font_tb[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    int          m_cyc [2];   // cycles since reset release
    logic [6:0]  m_snap[2];
    bit          m_ovr [2];
    logic [15:0] m_code[2];
    int          m_left[2];   // frames of override still to show
    logic [6:0]  e_seg [2];
    logic [3:0]  e_dig [2];
    bit          e_ack [2];
    bit          e_busy[2];
    int          req_left;

    function automatic logic [6:0] lit_seg(input int k, input int idx);
        logic [15:0] c;
        logic [6:0]  s;
        if (m_ovr[k]) begin
            c = m_code[k] >> (4 * idx);
            s = font_tb[c[3:0]];
        end else if (idx == 3) begin
            s = 7'h0E;
        end else if (idx == 2) begin
            s = 7'h7F;
        end else if (idx == 1) begin
            s = font_tb[int'(m_snap[k]) / 16];
        end else begin
            s = font_tb[int'(m_snap[k]) % 16];
        end
        return s;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_cyc[k]  = 0;
            m_snap[k] = 7'd0;
            m_ovr[k]  = 1'b0;
            m_code[k] = 16'h0;
            m_left[k] = 0;
            e_seg[k]  = 7'h7F;
            e_dig[k]  = 4'hF;
            e_ack[k]  = 1'b0;
            e_busy[k] = 1'b0;
        end
        req_left = 0;
    endtask

    // Advance instance k across one rising edge with the given inputs.
    task automatic model_step(input int k, input bit req, input logic [15:0] code, input logic [6:0] trk);
        int  slot_pos, digit;
        bit  frame_end;
        slot_pos  = m_cyc[k] % p_div[k];
        digit     = (m_cyc[k] / p_div[k]) % 4;
        frame_end = (slot_pos == p_div[k] - 1) && (digit == 3);
        if (slot_pos < p_blank[k]) begin
            e_seg[k] = 7'h7F;
            e_dig[k] = 4'hF;
        end else begin
            e_seg[k] = lit_seg(k, digit);
            e_dig[k] = ~(4'b0001 << digit);
        end
        if (slot_pos == 0 && digit == 0) m_snap[k] = trk;
        if (req) begin
            m_ovr[k]  = 1'b1;
            m_code[k] = code;
            m_left[k] = p_hold[k];
        end else if (m_ovr[k] && frame_end) begin
            m_left[k]--;
            if (m_left[k] == 0) m_ovr[k] = 1'b0;
        end
        e_ack[k]  = req;
        e_busy[k] = m_ovr[k];
        m_cyc[k]++;
    endtask

    task automatic check_outputs();
        check_val("u0.seg_n",   16'(seg0),  16'(e_seg[0]));
        check_val("u0.dig_n",   16'(dig0),  16'(e_dig[0]));
        check_val("u0.busy",    16'(busy0), 16'(e_busy[0]));
        check_val("u0.ovr_ack", 16'(ack0),  16'(e_ack[0]));
        check_val("u1.seg_n",   16'(seg1),  16'(e_seg[1]));
        check_val("u1.dig_n",   16'(dig1),  16'(e_dig[1]));
        check_val("u1.busy",    16'(busy1), 16'(e_busy[1]));
        check_val("u1.ovr_ack", 16'(ack1),  16'(e_ack[1]));
    endtask

    // Pick inputs for the next rising edge and advance both models.
    task automatic drive_and_model();
        int  r, pos0, dig_idx0;
        bit  req;
        pos0     = m_cyc[0] % p_div[0];
        dig_idx0 = (m_cyc[0] / p_div[0]) % 4;
        if ($urandom_range(0, 19) == 0) track = 7'($urandom_range(0, 127));
        req = 1'b0;
        if (req_left > 0) begin
            req = 1'b1;
            req_left--;
        end else begin
            r = $urandom_range(0, 99);
            if (r < 2) begin
                req = 1'b1;
            end else if (r == 2) begin
                req      = 1'b1;
                req_left = $urandom_range(1, 3);
            end else if (m_ovr[0] && m_left[0] == 1 && pos0 == p_div[0] - 1 &&
                         dig_idx0 == 3 && $urandom_range(0, 1) == 1) begin
                // Request coincident with the expiring frame end.
                req = 1'b1;
            end
        end
        ovr_req  = req;
        ovr_code = req ? 16'($urandom) : ovr_code;
        for (int k = 0; k < 2; k++) model_step(k, req, ovr_code, track);
    endtask

    task automatic do_reset();
        drive_and_model();
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check_val("rst.u0.seg_n",   16'(seg0),  16'h007F);
        check_val("rst.u0.dig_n",   16'(dig0),  16'h000F);
        check_val("rst.u0.busy",    16'(busy0), 16'h0000);
        check_val("rst.u0.ovr_ack", 16'(ack0),  16'h0000);
        check_val("rst.u1.seg_n",   16'(seg1),  16'h007F);
        check_val("rst.u1.dig_n",   16'(dig1),  16'h000F);
        check_val("rst.u1.busy",    16'(busy1), 16'h0000);
        check_val("rst.u1.ovr_ack", 16'(ack1),  16'h0000);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        check_outputs();
        drive_and_model();
    endtask

    initial begin
        int n_resets;
        rst      = 1'b1;
        ovr_req  = 1'b0;
        ovr_code = 16'h0;
        track    = 7'h2A;
        n_resets = 0;
        model_reset();
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_outputs();
        drive_and_model();
        for (int i = 0; i < 6000; i++) begin
            @(negedge clk);
            check_outputs();
            // Reset mid-override during a lit slot, a few times per run.
            if (i > 1500 * (n_resets + 1) && n_resets < 3 && m_ovr[0] &&
                (m_cyc[0] % p_div[0]) >= p_blank[0]) begin
                n_resets++;
                do_reset();
            end else begin
                drive_and_model();
            end
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
